// File: rtl/codificador_pkg.sv
// Types and sizes shared by the register-bank scan encoder and the bank's write-select decoder.
package codificador_pkg;

    localparam int unsigned N_LINHAS = 8;
    localparam int unsigned W_INDICE = 3;

    typedef enum logic [0:0] {
        OCIOSO,
        EMITINDO
    } estado_e;

endpackage

// File: rtl/codificador_prioridade.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set line and whether
// any line is set.
module codificador_prioridade
    import codificador_pkg::*;
#(
    parameter int unsigned N = N_LINHAS,
    parameter int unsigned W = W_INDICE
) (
    input  logic [N-1:0] linhas_i,
    output logic [W-1:0] indice_o,
    output logic         algum_o
);

    always_comb begin
        indice_o = '0;
        algum_o  = |linhas_i;
        // Scanning downward leaves the lowest set bit as the final assignment.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (linhas_i[i]) begin
                indice_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/codificador_varredura.sv
// Sequential scan encoder: emits the index of every set mask line, lowest first, one per
// valido/pronto handshake, pulsing fim when the scan completes.
module codificador_varredura
    import codificador_pkg::*;
#(
    parameter int unsigned N = N_LINHAS,
    parameter int unsigned W = W_INDICE
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         carrega,
    input  logic [N-1:0] mascara,
    input  logic         pronto,
    output logic [W-1:0] indice,
    output logic         valido,
    output logic         ocupado,
    output logic         fim
);

    estado_e        estado_q, estado_d;
    logic [N-1:0]   pendente_q, pendente_d;
    logic [W-1:0]   indice_q, indice_d;
    logic           valido_q, valido_d;
    logic           ocupado_q, ocupado_d;
    logic           fim_q, fim_d;

    logic [N-1:0]   pendente_limpo;
    logic [N-1:0]   enc_entrada;
    logic [W-1:0]   enc_indice;
    logic           enc_algum;
    logic           transfere;

    assign transfere      = valido_q & pronto;
    assign pendente_limpo = pendente_q & ~(N'(1) << indice_q);
    // One encoder serves both the initial load and every post-transfer step.
    assign enc_entrada    = (estado_q == OCIOSO) ? mascara : pendente_limpo;

    codificador_prioridade #(
        .N (N),
        .W (W)
    ) u_prioridade (
        .linhas_i (enc_entrada),
        .indice_o (enc_indice),
        .algum_o  (enc_algum)
    );

    always_comb begin
        estado_d   = estado_q;
        pendente_d = pendente_q;
        indice_d   = indice_q;
        valido_d   = valido_q;
        ocupado_d  = ocupado_q;
        fim_d      = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (carrega) begin
                    if (enc_algum) begin
                        pendente_d = mascara;
                        indice_d   = enc_indice;
                        valido_d   = 1'b1;
                        ocupado_d  = 1'b1;
                        estado_d   = EMITINDO;
                    end else begin
                        fim_d = 1'b1;
                    end
                end
            end
            EMITINDO: begin
                if (transfere) begin
                    pendente_d = pendente_limpo;
                    if (enc_algum) begin
                        indice_d = enc_indice;
                    end else begin
                        valido_d  = 1'b0;
                        ocupado_d = 1'b0;
                        fim_d     = 1'b1;
                        estado_d  = OCIOSO;
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado_q   <= OCIOSO;
            pendente_q <= '0;
            indice_q   <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pendente_q <= pendente_d;
            indice_q   <= indice_d;
            valido_q   <= valido_d;
            ocupado_q  <= ocupado_d;
            fim_q      <= fim_d;
        end
    end

    assign indice  = indice_q;
    assign valido  = valido_q;
    assign ocupado = ocupado_q;
    assign fim     = fim_q;

endmodule

// File: tb/tb_codificador_varredura.sv
// Scoreboard bench for codificador_varredura: expected indices are queued on load and
// compared on every accepted handshake.
module tb_codificador_varredura;

    logic       clock;
    logic       resetn;
    logic       carrega;
    logic [7:0] mascara;
    logic       pronto;
    logic [2:0] indice;
    logic       valido;
    logic       ocupado;
    logic       fim;

    int n_comp = 0;
    int n_erro = 0;
    int esperado[$];
    int n_fim = 0;

    codificador_varredura dut (
        .clock   (clock),
        .resetn  (resetn),
        .carrega (carrega),
        .mascara (mascara),
        .pronto  (pronto),
        .indice  (indice),
        .valido  (valido),
        .ocupado (ocupado),
        .fim     (fim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_comp++;
        if (obs != exp) begin
            n_erro++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: a handshake seen here completes at the next rising edge.
    always @(negedge clock) begin
        if (resetn && valido && pronto) begin
            if (esperado.size() == 0) begin
                check("indice_extra", int'(indice), -1);
            end else begin
                int e;
                e = esperado.pop_front();
                check("indice", int'(indice), e);
            end
        end
        if (resetn && fim) n_fim++;
    end

    // Load into an idle block; expected indices come from the mask itself.
    task automatic carregar(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) esperado.push_back(i);
        carrega = 1'b1;
        mascara = m;
        @(posedge clock);
        #1;
        carrega = 1'b0;
        mascara = 8'h00;
        check("valido_carga", int'(valido), int'(m != 8'h00));
        check("ocupado_carga", int'(ocupado), int'(m != 8'h00));
    endtask

    // Runs cycles until fim, optionally toggling pronto each cycle; returns at fim's negedge.
    task automatic esperar_fim(input bit alterna, input int limite);
        bit visto;
        visto = 1'b0;
        for (int i = 0; i < limite && !visto; i++) begin
            @(negedge clock);
            if (fim) begin
                visto = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                if (alterna) pronto = ~pronto;
            end
        end
        check("fim_visto", int'(visto), 1);
        check("ocupado_no_fim", int'(ocupado), 0);
        check("valido_no_fim", int'(valido), 0);
        check("fila_vazia", esperado.size(), 0);
    endtask

    initial begin
        resetn  = 1'b0;
        carrega = 1'b0;
        mascara = 8'h00;
        pronto  = 1'b1;
        #12;
        check("rst_indice", int'(indice), 0);
        check("rst_valido", int'(valido), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_fim", int'(fim), 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Reset mid-scan after three accepted indices.
        carregar(8'hFF);
        repeat (3) @(posedge clock);
        #2;
        check("antes_reset_fila", esperado.size(), 5);
        resetn = 1'b0;
        #1;
        check("reset_meio_valido", int'(valido), 0);
        check("reset_meio_ocupado", int'(ocupado), 0);
        check("reset_meio_indice", int'(indice), 0);
        check("reset_meio_fim", int'(fim), 0);
        esperado.delete();
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        carregar(8'h01);
        esperar_fim(1'b0, 20);

        // Basic scan, then fim must drop after one cycle.
        @(posedge clock);
        #1;
        carregar(8'b1010_0101);
        esperar_fim(1'b0, 20);
        @(posedge clock);
        #1;
        check("fim_um_ciclo", int'(fim), 0);

        // Backpressure holds index 1 stable.
        pronto = 1'b0;
        carregar(8'b1000_0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("retido_indice", int'(indice), 1);
            check("retido_valido", int'(valido), 1);
        end
        pronto = 1'b1;
        esperar_fim(1'b0, 20);

        // Empty mask: single fim, never valid or busy.
        @(posedge clock);
        #1;
        n_fim = 0;
        carregar(8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("vazio_valido", int'(valido), 0);
            check("vazio_ocupado", int'(ocupado), 0);
        end
        check("vazio_n_fim", n_fim, 1);

        // Load while busy is ignored; load in the fim cycle is accepted.
        carregar(8'hF0);
        carrega = 1'b1;
        mascara = 8'h0F;
        @(posedge clock);
        #1;
        carrega = 1'b0;
        mascara = 8'h00;
        esperar_fim(1'b0, 20);
        carregar(8'h0F);
        esperar_fim(1'b0, 20);

        // Extreme bits.
        @(posedge clock);
        #1;
        carregar(8'h80);
        esperar_fim(1'b0, 20);
        @(posedge clock);
        #1;
        carregar(8'hFF);
        esperar_fim(1'b1, 40);
        pronto = 1'b1;

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
        $finish;
    end

endmodule
